// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for a word-only data memory.
// Partial-word stores are executed as a read-modify-write pair.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p0_req_valid,
    output logic                  p0_req_ready,
    input  logic [ADDR_W-1:0]     p0_req_addr,
    input  logic                  p0_req_we,
    input  logic [DATA_W/8-1:0]   p0_req_be,
    input  logic [DATA_W-1:0]     p0_req_wdata,
    output logic                  p0_rsp_valid,
    output logic [DATA_W-1:0]     p0_rsp_rdata,
    input  logic                  p1_req_valid,
    output logic                  p1_req_ready,
    input  logic [ADDR_W-1:0]     p1_req_addr,
    input  logic                  p1_req_we,
    input  logic [DATA_W/8-1:0]   p1_req_be,
    input  logic [DATA_W-1:0]     p1_req_wdata,
    output logic                  p1_rsp_valid,
    output logic [DATA_W-1:0]     p1_rsp_rdata,
    output logic [ADDR_W-1:0]     mem_access_addr,
    output logic [DATA_W-1:0]     mem_in,
    output logic                  mem_write_en,
    output logic                  mem_read_en,
    input  logic [DATA_W-1:0]     mem_out,
    output logic                  busy
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
        logic              port;
    } req_t;

    state_t            state, state_nxt;
    req_t              cur, sel;
    logic              last_grant, grant, hs;
    logic [DATA_W-1:0] merge;
    logic [1:0]        rsp_valid;
    logic [DATA_W-1:0] rsp_rdata [2];
    logic              unused_addr_lsb;

    // Contention goes to the port that did not win last time.
    always_comb begin
        grant = (p0_req_valid && p1_req_valid) ? ~last_grant : p1_req_valid;
        hs    = rst_n && (state == IDLE) && (p0_req_valid || p1_req_valid);
        sel.addr  = grant ? p1_req_addr  : p0_req_addr;
        sel.we    = grant ? p1_req_we    : p0_req_we;
        sel.be    = grant ? p1_req_be    : p0_req_be;
        sel.wdata = grant ? p1_req_wdata : p0_req_wdata;
        sel.port  = grant;
    end

    assign p0_req_ready = hs && !grant;
    assign p1_req_ready = hs && grant;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (hs) begin
                    if (!sel.we)
                        state_nxt = RD;
                    else if (sel.be == '1 || sel.be == '0)
                        state_nxt = WR;
                    else
                        state_nxt = RMW_RD;
                end
            end
            RMW_RD:  state_nxt = RMW_WR;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            cur          <= '0;
            merge        <= '0;
            rsp_valid    <= '0;
            rsp_rdata[0] <= '0;
            rsp_rdata[1] <= '0;
        end else begin
            state     <= state_nxt;
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (hs) begin
                        cur        <= sel;
                        last_grant <= grant;
                    end
                end
                RD: begin
                    rsp_valid[cur.port] <= 1'b1;
                    rsp_rdata[cur.port] <= mem_out;
                end
                WR, RMW_WR: begin
                    rsp_valid[cur.port] <= 1'b1;
                    rsp_rdata[cur.port] <= '0;
                end
                RMW_RD: begin
                    for (int i = 0; i < BE_W; i++)
                        merge[8*i +: 8] <= cur.be[i] ? cur.wdata[8*i +: 8] : mem_out[8*i +: 8];
                end
                default: ;
            endcase
        end
    end

    // Every memory-side output is forced low while reset is asserted.
    assign mem_read_en     = rst_n && (state == RD || state == RMW_RD);
    assign mem_write_en    = rst_n && ((state == WR && cur.we && cur.be != '0) || state == RMW_WR);
    assign mem_in          = !rst_n ? '0 :
                             (state == RMW_WR) ? merge :
                             (state == WR) ? cur.wdata : '0;
    assign mem_access_addr = (rst_n && state != IDLE) ? {cur.addr[ADDR_W-1:2], 2'b00} : '0;
    assign busy            = (state != IDLE);
    assign unused_addr_lsb = ^cur.addr[1:0];

    assign p0_rsp_valid = rsp_valid[0];
    assign p1_rsp_valid = rsp_valid[1];
    assign p0_rsp_rdata = rsp_rdata[0];
    assign p1_rsp_rdata = rsp_rdata[1];
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the word-aligned data memory (32-bit rows, combinational read, write on posedge).
- Requesters: port 0 (core load/store unit) and port 1 (loader/debug DMA).
- Serialises requests with round-robin priority and drives the memory's address, write and read strobes.
- The memory is word-write only, so byte/halfword stores are built as read-modify-write sequences.

Parameters:
- ADDR_W, 32, width of request and memory addresses.
- DATA_W, 32, data width; byte enables are DATA_W/8 bits wide. Only 32 is supported.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  synchronous active-low reset.
- pN_req_valid  input  1  request valid, for N = 0 and 1.
- pN_req_ready  output  1  request accepted this cycle.
- pN_req_addr  input  ADDR_W  byte address; bits [1:0] are ignored.
- pN_req_we  input  1  1 = write, 0 = read.
- pN_req_be  input  4  byte enables for writes; ignored for reads.
- pN_req_wdata  input  32  write data.
- pN_rsp_valid  output  1  one-cycle completion pulse.
- pN_rsp_rdata  output  32  read data; 0 for writes.
- mem_access_addr  output  ADDR_W  memory address, bits [1:0] forced to 0.
- mem_in  output  32  memory write data.
- mem_write_en  output  1  memory write strobe.
- mem_read_en  output  1  memory read enable.
- mem_out  input  32  memory read data (combinational).
- busy  output  1  high when state is not IDLE.

Behaviour:
- Reset:
  - State goes to IDLE and last_grant is set to 1, so port 0 wins the first contention.
  - All rsp_valid/rsp_rdata registers clear to 0.
  - All mem_* outputs are 0 and both req_ready are 0 while rst_n = 0.
  - mem_write_en is gated by rst_n: no memory write occurs on any edge where rst_n = 0.
- States: IDLE, RD, WR, RMW_RD, RMW_WR.
- IDLE arbitration:
  - Only one valid port: that port is granted.
  - Both valid: grant the port != last_grant.
  - pN_req_ready = granted & valid, combinational, asserted in IDLE only.
- On handshake, latch addr, we, be, wdata and port id; update last_grant; then transition:
  - read goes to RD;
  - write with be = 4'hF or be = 4'h0 goes to WR;
  - any other write goes to RMW_RD.
- RD:
  - mem_read_en = 1.
  - Capture mem_out into the granted port's rsp_rdata.
  - Go to IDLE and set rsp_valid (registered).
- WR:
  - mem_write_en = (be != 0), mem_in = wdata.
  - be = 0 is a no-op write: no memory write, but the normal write response is still returned.
  - rsp_rdata = 0, rsp_valid set, go to IDLE.
- RMW_RD:
  - mem_read_en = 1.
  - merge[8i+7:8i] = be[i] ? wdata byte i : mem_out byte i, registered.
  - Go to RMW_WR.
- RMW_WR: mem_write_en = 1, mem_in = merge, set rsp_valid, go to IDLE.
- Latency, with the accept edge at cycle T:
  - memory access in T+1 (RMW: T+1 read, T+2 write);
  - rsp_valid high in T+2 (RMW: T+3) for exactly one cycle.
- A new request may be accepted in the same IDLE cycle that rsp_valid is high, giving back-to-back ops every 2 cycles (3 for RMW).
- Outside RD/RMW_RD mem_read_en = 0; outside WR/RMW_WR mem_write_en = 0.
- mem_access_addr = {latched addr[ADDR_W-1:2], 2'b00} in non-IDLE states and 0 in IDLE. Address wrap is the memory's concern.
- Requests are not dropped: a valid port that is not granted waits, and its inputs must stay stable until ready.
- Reset mid-operation: the sequence is abandoned, no pending response is issued, and no write is committed.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with both ports valid -> both ready = 0, mem_write_en = 0, mem_read_en = 0, busy = 0, rsp_valid = 0.
- Full-word write: p0 write addr 0x0000_000A, wdata 0xDEADBEEF, be 4'hF -> at T+1: mem_access_addr = 0x8, mem_in = 0xDEADBEEF, mem_write_en = 1 for one cycle; p0_rsp_valid = 1 at T+2.
- Read: p0 read addr 0x8 -> mem_read_en = 1 at T+1; p0_rsp_valid = 1 with p0_rsp_rdata = 0xDEADBEEF at T+2.
- Byte RMW: p1 write addr 0x8, be 4'b0010, wdata 0x0000AA00 -> RMW_RD at T+1, then mem_in = 0xDEADAAEF with mem_write_en = 1 at T+2; p1_rsp_valid at T+3; a following read of 0x8 returns 0xDEADAAEF.
- Contention: both ports issue reads continuously after reset -> grants alternate p0, p1, p0, ... (one handshake every 2 cycles); be = 0 write -> no mem_write_en, rsp at T+2.
- Reset mid-RMW: drop rst_n in the RMW_RD cycle -> no mem_write_en on any following edge, no rsp_valid, busy = 0 after the reset edge; the memory word is unchanged.
